// File: rtl/keypad_pkg.sv
// Shared types and the key layout decode for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  localparam logic [3:0] KEY_CLEAR = 4'hE;

  // Rows top to bottom: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D, with * = E and # = F.
  function automatic logic [3:0] decode_key(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'h0;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Divides clk down to a one-cycle tick that paces column dwell and debounce.
module scan_tick_gen #(
  parameter int CLK_FREQ  = 100000000,
  parameter int SCAN_FREQ = 1000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int DIV = CLK_FREQ / SCAN_FREQ;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DW-1:0] div;

  assign tick = (div == DW'(DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row sync, debounce, decode and a
// 4-digit BCD entry register laid out for the seven-segment multiplexer.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int CLK_FREQ       = 100000000,
  parameter int SCAN_FREQ      = 1000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] digits
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_TICKS);
  localparam bit ONE_TICK = (DEBOUNCE_TICKS == 1);

  logic          tick;
  logic [3:0]    row_m, row_s;
  state_t        state;
  logic [1:0]    col_idx, cap_row, prio_row;
  logic [CW-1:0] cnt, rcnt, cnt_nxt, rcnt_nxt;
  logic          any_low, accept, release_done;
  logic [3:0]    code;

  scan_tick_gen #(.CLK_FREQ(CLK_FREQ), .SCAN_FREQ(SCAN_FREQ)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign col_out = ~(4'b0001 << col_idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_m <= 4'hF;
      row_s <= 4'hF;
    end else begin
      row_m <= row_in;
      row_s <= row_m;
    end
  end

  // Lowest-numbered low row wins when several keys share the driven column.
  always_comb begin
    prio_row = 2'd0;
    if (!row_s[0])      prio_row = 2'd0;
    else if (!row_s[1]) prio_row = 2'd1;
    else if (!row_s[2]) prio_row = 2'd2;
    else if (!row_s[3]) prio_row = 2'd3;
  end

  assign any_low  = (row_s != 4'hF);
  assign cnt_nxt  = cnt + CW'(1);
  assign rcnt_nxt = rcnt + CW'(1);
  assign code     = decode_key(prio_row, col_idx);

  assign accept = tick && any_low &&
                  ((state == SCAN && ONE_TICK) ||
                   (state == DEBOUNCE && prio_row == cap_row && cnt_nxt == CNT_DONE));
  assign release_done = tick && !any_low &&
                        ((state == HELD && ONE_TICK) ||
                         (state == RELEASE && rcnt_nxt == CNT_DONE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      cap_row   <= 2'd0;
      cnt       <= '0;
      rcnt      <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      digits    <= 16'h0000;
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (!any_low) begin
              col_idx <= col_idx + 2'd1;
            end else begin
              cap_row <= prio_row;
              cnt     <= CW'(1);
              state   <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (any_low && prio_row == cap_row) begin
              cnt <= cnt_nxt;
            end else begin
              cnt     <= '0;
              col_idx <= col_idx + 2'd1;
              state   <= SCAN;
            end
          end
          HELD: begin
            if (!any_low) begin
              rcnt  <= CW'(1);
              state <= RELEASE;
            end
          end
          RELEASE: begin
            if (!any_low) begin
              rcnt <= rcnt_nxt;
            end else begin
              rcnt  <= '0;
              state <= HELD;
            end
          end
          default: state <= SCAN;
        endcase
        // Acceptance and release completion override the per-state updates above.
        if (accept) begin
          key_code  <= code;
          key_valid <= 1'b1;
          key_held  <= 1'b1;
          cnt       <= '0;
          state     <= HELD;
          if (code < 4'd10) begin
            digits <= {digits[11:0], code};
          end else if (code == KEY_CLEAR) begin
            digits <= 16'h0000;
          end
        end
        if (release_done) begin
          key_held <= 1'b0;
          rcnt     <= '0;
          col_idx  <= col_idx + 2'd1;
          state    <= SCAN;
        end
      end
    end
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Time-multiplexed 4x4 matrix keypad scanner. It is the input-side counterpart of the 4-digit multiplexed seven-segment display path. It drives one keypad column low at a time and samples the rows. It then debounces, decodes and reports one hex key code per press. A 4-digit BCD entry register is formatted so it can feed the display multiplexer directly.

Parameters:
CLK_FREQ, 100000000, input clock frequency in Hz
SCAN_FREQ, 1000, column-advance tick rate in Hz (tick period = CLK_FREQ/SCAN_FREQ cycles, integer, >= 2)
DEBOUNCE_TICKS, 4, consecutive stable ticks needed to accept a press or a release (>= 1)

Ports:
clk  in  1  system clock; the only clock in the block
reset  in  1  asynchronous, active-high reset
row_in  in  4  keypad rows, active-low (external pull-ups), asynchronous to clk
col_out  out  4  keypad column drive, active-low, exactly one bit low
key_code  out  4  code of the last accepted key
key_valid  out  1  single-cycle pulse on acceptance of a key
key_held  out  1  high from acceptance until the release is debounced
digits  out  16  four BCD digits [15:12]..[3:0]; newest digit in [3:0]

Behaviour:
- Reset (async, immediate): col_out=4'b1110, key_code=0, key_valid=0, key_held=0, digits=0, state=SCAN, divider=0, col_idx=0, counters=0.
- row_in passes through a 2-flop synchronizer. All decisions use the synchronized rows (row_s).
- Tick: the divider counts 0..CLK_FREQ/SCAN_FREQ-1. tick=1 for exactly one cycle when the divider wraps.
- col_out = ~(4'b0001 << col_idx). Rows are evaluated only on tick, i.e. at the end of the column's dwell time.
- Row select: the lowest-index low bit of row_s has priority. Other simultaneously pressed keys are ignored.
- Layout (row,col -> code):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E(*) 0 F(#) D
- FSM states SCAN, DEBOUNCE, HELD, RELEASE:
  - SCAN: on tick, if row_s==4'hF, col_idx increments and wraps 3->0. Otherwise capture the row index, cnt=1, go to DEBOUNCE, and freeze the column.
  - DEBOUNCE: on tick, if the priority row equals the captured row, cnt++. Any other pattern (release or a different row) returns to SCAN with col_idx+1 and no output. When cnt reaches DEBOUNCE_TICKS, the key is accepted (DEBOUNCE_TICKS=1 accepts on the entry tick itself). On acceptance:
    - key_code updates.
    - key_valid pulses in the cycle after the accepting tick.
    - key_held=1.
    - digits update.
    - Go to HELD.
  - HELD: column stays frozen. A tick with row_s==4'hF sets rcnt=1 and goes to RELEASE. No auto-repeat.
  - RELEASE: a tick with all rows high increments rcnt. A tick with any row low returns to HELD (rcnt=0). When rcnt reaches DEBOUNCE_TICKS: key_held=0, col_idx+1, go to SCAN.
- Digits update:
  - Code 0-9: digits <= {digits[11:0], code}; the oldest digit is dropped.
  - Code E: digits <= 0.
  - Codes A-D and F: digits unchanged; key_code and key_valid still produced.
- Latency: press acceptance occurs DEBOUNCE_TICKS-1 ticks after detection, plus 1 cycle to key_valid. Worst-case detection is 4 ticks plus 2 synchronizer cycles.
- key_valid never asserts in two consecutive cycles and never asserts twice per physical press.
- Reset mid-operation: all state is abandoned and scanning restarts at column 0. A key still held after reset is re-detected as a new press.

Decomposition:
- Package keypad_pkg holds:
  - the FSM state enum (SCAN, DEBOUNCE, HELD, RELEASE);
  - the KEY_CLEAR=4'hE constant;
  - the layout decode function (row idx, col idx -> 4-bit code).
- Sub-module scan_tick_gen (parameters CLK_FREQ, SCAN_FREQ; ports clk, reset, tick) isolates the divider.
- The synchronizer, FSM, column counter and digit register stay in keypad_scanner.

Test Plan:
Bench parameters: CLK_FREQ=100, SCAN_FREQ=10 (tick every 10 cycles), DEBOUNCE_TICKS=3.
1. Reset, no keys -> col_out=1110 during reset. Advances to 1101 after the first tick, cycles 1011, 0111, then wraps to 1110. key_valid stays 0.
2. Hold row1 low while col1 is driven (key 5) for 20 ticks, then release -> exactly one key_valid pulse, key_code=5, digits=16'h0005. key_held falls 3 ticks after release; scanning resumes at col2.
3. Press/release keys 1,2,3,4,5 in sequence -> five key_valid pulses and digits=16'h2345.
4. Bounce: key 8 low for 2 ticks, then high -> no key_valid, key_held=0, scanning resumes. Rows glitch high for 1 tick during HELD -> no second pulse.
5. After digits=16'h0042, press key A -> key_code=A, digits stay 16'h0042. Press * -> key_code=E, digits=16'h0000. Keys 4 and 7 together in col0 -> key_code=4 only.
6. Assert reset while in HELD (key 9 still pressed) -> outputs return to reset values immediately, mid-cycle. After release of reset, key 9 is re-detected and accepted once, with digits=16'h0009.
